// File: rtl/comparador_pin_pkg.sv
// Shared types and constants for the PIN entry/compare stage.
// Digit width, largest BCD digit and the FSM state encoding.
package comparador_pin_pkg;

  localparam int DIGITO_W   = 4;
  localparam int DIGITO_MAX = 9;

  typedef enum logic [1:0] {
    IDLE,
    COLETA,
    COMPARA
  } estado_t;

endpackage

// File: rtl/comparador_pin_temporizador_inatividade.sv
// Loadable saturating down-counter with a zero flag.
// Used as the idle-time watchdog between keypad digits.
module temporizador_inatividade #(
  parameter int MAX = 255,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         carrega,
  input  logic [W-1:0] valor,
  input  logic         conta,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // next count: load wins, otherwise decrement and hold at zero
  always_comb begin
    cnt_d = cnt_q;
    if (carrega) begin
      cnt_d = valor;
    end else if (conta && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // counter register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/comparador_pin.sv
// PIN entry and compare stage ahead of the attempt counter.
// Collects digits, compares on confirm, pulses erro or acerto.
module comparador_pin
  import comparador_pin_pkg::*;
#(
  parameter int N_DIGITOS = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [DIGITO_W-1:0]             digito,
  input  logic                            digito_valido,
  input  logic                            confirma,
  input  logic                            cancela,
  input  logic [DIGITO_W*N_DIGITOS-1:0]   pin_ref,
  input  logic                            bloqueio,
  output logic                            erro,
  output logic                            acerto,
  output logic [3:0]                      n_digitos,
  output logic                            ocupado
);

  localparam int BUF_W = DIGITO_W * N_DIGITOS;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  estado_t            estado_q;
  estado_t            estado_d;
  logic [BUF_W-1:0]   buffer_q;
  logic [BUF_W-1:0]   buffer_d;
  logic [3:0]         n_q;
  logic [3:0]         n_d;
  logic               erro_q;
  logic               erro_d;
  logic               acerto_q;
  logic               acerto_d;

  logic               tmr_carrega;
  logic               tmr_conta;
  logic               tmr_zero;
  logic               dig_ok;

  assign dig_ok = digito_valido &&
                  (digito <= DIGITO_W'(DIGITO_MAX));

  temporizador_inatividade #(
    .MAX (TIMEOUT),
    .W   (TMR_W)
  ) u_tmr (
    .clk     (clk),
    .rst_n   (rst_n),
    .carrega (tmr_carrega),
    .valor   (TMR_W'(TIMEOUT)),
    .conta   (tmr_conta),
    .zero    (tmr_zero)
  );

  // entry FSM next-state: priority bloqueio > cancela > confirma > digit > timeout
  always_comb begin
    estado_d    = estado_q;
    buffer_d    = buffer_q;
    n_d         = n_q;
    erro_d      = 1'b0;
    acerto_d    = 1'b0;
    tmr_carrega = 1'b0;
    tmr_conta   = 1'b0;
    unique case (estado_q)
      IDLE: begin
        if (dig_ok && !bloqueio) begin
          buffer_d    = BUF_W'(digito);
          n_d         = 4'd1;
          tmr_carrega = 1'b1;
          estado_d    = COLETA;
        end
      end
      COLETA: begin
        if (bloqueio || cancela) begin
          buffer_d = '0;
          n_d      = '0;
          estado_d = IDLE;
        end else if (confirma) begin
          estado_d = COMPARA;
        end else if (dig_ok) begin
          tmr_carrega = 1'b1;
          if (n_q < 4'(N_DIGITOS)) begin
            buffer_d = (buffer_q << DIGITO_W) | BUF_W'(digito);
            n_d      = n_q + 4'd1;
          end
        end else if (tmr_zero) begin
          buffer_d = '0;
          n_d      = '0;
          estado_d = IDLE;
        end else begin
          tmr_conta = 1'b1;
        end
      end
      COMPARA: begin
        if ((n_q == 4'(N_DIGITOS)) && (buffer_q == pin_ref)) begin
          acerto_d = 1'b1;
        end else begin
          erro_d = 1'b1;
        end
        buffer_d = '0;
        n_d      = '0;
        estado_d = IDLE;
      end
      default: begin
        buffer_d = '0;
        n_d      = '0;
        estado_d = IDLE;
      end
    endcase
  end

  // state, buffer and result pulse registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_q <= IDLE;
      buffer_q <= '0;
      n_q      <= '0;
      erro_q   <= 1'b0;
      acerto_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      buffer_q <= buffer_d;
      n_q      <= n_d;
      erro_q   <= erro_d;
      acerto_q <= acerto_d;
    end
  end

  assign erro      = erro_q;
  assign acerto    = acerto_q;
  assign n_digitos = n_q;
  assign ocupado   = (estado_q != IDLE);

endmodule

// File: doc/comparador_pin.md
Name: comparador_pin

Overview:
- PIN-entry and compare stage that sits directly upstream of the attempt counter. It drives the counter's `saidaComparador` input and consumes its `ejeta` output as `bloqueio`.
- Collects N decimal digits from the keypad decoder and compares them against the stored reference PIN on confirm.
- Emits a clean, registered, one-cycle `erro` pulse on mismatch, or an `acerto` pulse on match.
- Handles cancel, inactivity timeout and lockout.

Parameters:
N_DIGITOS, 4, number of PIN digits (1..8)
TIMEOUT, 255, idle clk cycles allowed between digits before the entry is discarded (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous reset, active-low
digito  in  4  BCD digit from keypad decoder
digito_valido  in  1  one-cycle strobe, digito valid
confirma  in  1  one-cycle strobe, user presses confirm
cancela  in  1  one-cycle strobe, user presses cancel
pin_ref  in  4*N_DIGITOS  stored PIN, most significant digit = first digit entered
bloqueio  in  1  lockout from attempt counter (its ejeta); high = ignore all input
erro  out  1  one-cycle pulse, wrong or incomplete PIN (to saidaComparador)
acerto  out  1  one-cycle pulse, PIN matched
n_digitos  out  4  digits captured so far (0..N_DIGITOS)
ocupado  out  1  high while an entry is in progress (state COLETA or COMPARA)

Behaviour:
- Reset: all outputs and registers are evaluated only on rising clk when rst_n=0.
  - Reset values: erro=0, acerto=0, n_digitos=0, ocupado=0, buffer=0, timer=0, state=IDLE.
  - Reset mid-entry discards the partial PIN; no pulse is emitted.
- FSM states: IDLE, COLETA, COMPARA.
- IDLE:
  - A valid digit (digito_valido=1, digito<=9, bloqueio=0) shifts into the buffer, sets n_digitos=1, loads timer=TIMEOUT, and moves to COLETA.
  - confirma or cancela in IDLE is ignored.
- COLETA:
  - Priority per edge: bloqueio > cancela > confirma > digito_valido > timeout.
  - bloqueio=1: clear buffer and n_digitos, go to IDLE, no pulse.
  - cancela: clear buffer and n_digitos, go to IDLE, no pulse.
  - confirma: go to COMPARA; buffer frozen.
  - Valid digit with n_digitos<N_DIGITOS: shift the buffer left by 4, insert the digit, increment n_digitos, reload timer.
  - Valid digit with n_digitos==N_DIGITOS: ignored; timer still reloads.
  - digito>9: ignored entirely; no timer reload.
  - Otherwise timer decrements. When timer==0 at an edge with no other event: clear the entry and go to IDLE; no erro pulse (a timeout does not count as an attempt).
- COMPARA (exactly one cycle):
  - n_digitos==N_DIGITOS and buffer==pin_ref: acerto=1. Any other case, including a short entry: erro=1.
  - Next edge: pulse cleared, buffer and n_digitos cleared, state goes to IDLE.
- Latency: confirma sampled at edge E → pulse high from edge E+1 to edge E+2 (exactly one clk period).
- erro and acerto are never high together. Both come straight from flops, so they are glitch-free and safe for a downstream posedge trigger.
- bloqueio=1 in COMPARA does not suppress the pending result; the state still returns to IDLE.
- While bloqueio=1, the block stays in IDLE and every strobe is ignored.
- pin_ref is sampled only in COMPARA. Changes during COLETA are harmless.
- Timer width is clog2(TIMEOUT+1). Counters saturate and never wrap.

Decomposition:
- Shared package holds:
  - state enum (IDLE, COLETA, COMPARA)
  - DIGITO_W=4
  - DIGITO_MAX=9
- One natural sub-module: temporizador_inatividade. It is a loadable down-counter with inputs carrega/conta and a zero flag, and is reusable elsewhere in the lock design.

Test Plan:
- Correct PIN: pin_ref=16'h1234; digits 1,2,3,4 then confirma → acerto=1 for exactly 1 cycle at E+1, erro stays 0, n_digitos returns to 0.
- Wrong PIN: pin_ref=16'h1234; digits 1,2,3,5, confirma → erro=1 for one cycle. Repeat 3× into contadorTent → its ejeta=1; further digits ignored, ocupado stays 0.
- Short entry and overflow:
  - digits 1,2 then confirma → erro pulse.
  - digits 1,2,3,4,9 then confirma → n_digitos holds at 4 and acerto fires (the 9 is ignored).
- Cancel, timeout and invalid digit, each followed by a fresh correct entry that must still give acerto:
  - digits 1,2, cancela → IDLE, no pulse.
  - With TIMEOUT=8: digit 1, then 9 idle cycles → IDLE, no pulse.
  - digito=4'hA → no change.
- Simultaneous strobes: cancela and confirma on the same edge → cancel wins, no pulse. confirma and digito_valido on the same edge → compare uses the buffer without the new digit.
- Reset mid-entry: rst_n=0 for 1 cycle after 3 digits → all outputs 0, state IDLE; no pulse in the following 5 cycles.
